// File: rtl/spi_slave_axis_egress_from_clk.sv
// spi_slave_axis_egress_from_clk: AXIS byte FIFO feeding a prefetched SPI slave transmit holding register.
// Optional macro SPI_EGRESS_UNDERRUN_CNT_EN adds a saturating underrun counter with synchronous clear.
`default_nettype none

module spi_slave_axis_egress_from_clk #(
   parameter int         DEST_WIDTH = 8,
   parameter int         ID_WIDTH   = 8,
   parameter int         FIFO_AW    = 3,
   parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
   input  logic                  clk,
   input  logic                  resn,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic [ID_WIDTH-1:0]   s_axis_tid,
   input  logic                  spi_byte_req,
   output logic [7:0]            spi_tx_data,
   output logic [DEST_WIDTH-1:0] spi_tx_dest,
   output logic [ID_WIDTH-1:0]   spi_tx_id,
   output logic                  spi_tx_valid,
   output logic                  underrun,
`ifdef SPI_EGRESS_UNDERRUN_CNT_EN
   input  logic                  underrun_count_clr,
   output logic [15:0]           underrun_count,
`endif
   output logic [FIFO_AW:0]      fifo_level
);

   localparam int               DEPTH    = 2**FIFO_AW;
   localparam int               EW       = 8 + DEST_WIDTH + ID_WIDTH;
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);

   logic [EW-1:0]    mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;
   logic [FIFO_AW:0] level;
   logic [FIFO_AW:0] level_nxt;
   logic [EW-1:0]    rd_entry;
   logic             req_s1;
   logic             req_s2;
   logic             req_s3;
   logic [1:0]       sync_cnt;
   logic             req_evt;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   assign level      = wr_ptr - rd_ptr;
   assign fifo_level = level;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign push       = s_axis_tvalid && s_axis_tready;
   assign rd_entry   = mem[rd_ptr[FIFO_AW-1:0]];

   // Edges are only trusted once the whole synchroniser has been refilled after reset,
   // so a stale request level present at reset release never becomes a request.
   assign req_evt = (req_s2 ^ req_s3) && (sync_cnt == 2'd3);

   // Pop either to replace a consumed byte or to prefetch into an empty holding register.
   assign pop = !fifo_empty && (req_evt ? spi_tx_valid : !spi_tx_valid);

   assign level_nxt = level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[FIFO_AW-1:0]] <= {s_axis_tid, s_axis_tdest, s_axis_tdata};
      end
   end

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         s_axis_tready <= 1'b0;
         req_s1        <= 1'b0;
         req_s2        <= 1'b0;
         req_s3        <= 1'b0;
         sync_cnt      <= 2'd0;
         spi_tx_data   <= IDLE_BYTE;
         spi_tx_dest   <= '0;
         spi_tx_id     <= '0;
         spi_tx_valid  <= 1'b0;
         underrun      <= 1'b0;
      end else begin
         req_s1 <= spi_byte_req;
         req_s2 <= req_s1;
         req_s3 <= req_s2;
         if (sync_cnt != 2'd3) begin
            sync_cnt <= sync_cnt + 2'd1;
         end

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         s_axis_tready <= (level_nxt != FULL_LVL);

         underrun <= req_evt && !spi_tx_valid;

         if (pop) begin
            {spi_tx_id, spi_tx_dest, spi_tx_data} <= rd_entry;
            spi_tx_valid                          <= 1'b1;
         end else if (req_evt && spi_tx_valid) begin
            spi_tx_valid <= 1'b0;
            spi_tx_data  <= IDLE_BYTE;
         end
      end
   end

`ifdef SPI_EGRESS_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         underrun_count <= 16'd0;
      end else if (underrun_count_clr) begin
         underrun_count <= 16'd0;
      end else if (underrun && (underrun_count != 16'hFFFF)) begin
         underrun_count <= underrun_count + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire
